// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared state encoding, source ids and bus widths for the SRAM port arbiter
package sram_arb_pkg;
    localparam int AW = 20;
    localparam int DW = 16;
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
    localparam logic SRC_VGA = 1'b0;
    localparam logic SRC_CPU = 1'b1;
endpackage

// File: rtl/sram_access_seq.sv
// sram_access_seq: runs one SRAM access at a time (RD/WR strobe timing, registered pins, read capture)
//  in:  start/start_* describe the access granted this cycle; sram_dq_in is the pin read data
//  out: state/src of the access in flight, captured read data per requester, registered SRAM pins
module sram_access_seq import sram_arb_pkg::*; #(
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          start_src,
    input  logic          start_write,
    input  logic [AW-1:0] start_addr,
    input  logic [DW-1:0] start_wdata,
    input  logic [1:0]    start_be,
    output state_t        state,
    output logic          src,
    output logic [DW-1:0] vga_rdata,
    output logic [DW-1:0] cpu_rdata,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_dq_out,
    output logic          sram_dq_oe,
    input  logic [DW-1:0] sram_dq_in,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic          sram_ub_n,
    output logic          sram_lb_n
);
    localparam int MAXC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic src_q, src_d;
    logic [1:0] be_q, be_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] dq_out_q, dq_out_d, vga_rdata_q, vga_rdata_d, cpu_rdata_q, cpu_rdata_d;
    logic ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, ub_n_q, ub_n_d, lb_n_q, lb_n_d;
    logic dq_oe_q, dq_oe_d;
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        src_d       = src_q;
        be_d        = be_q;
        addr_d      = addr_q;
        dq_out_d    = dq_out_q;
        vga_rdata_d = vga_rdata_q;
        cpu_rdata_d = cpu_rdata_q;
        case (state_q)
            RD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(RD_CYCLES - 1)) begin
                    state_d = DONE;
                    if (src_q == SRC_VGA) vga_rdata_d = sram_dq_in;
                    else cpu_rdata_d = sram_dq_in;
                end
            end
            WR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WR_CYCLES - 1)) state_d = DONE;
            end
            default: begin
                state_d = start ? (start_write ? WR : RD) : IDLE;
                if (start) begin
                    cnt_d    = '0;
                    src_d    = start_src;
                    be_d     = start_be;
                    addr_d   = start_addr;
                    dq_out_d = start_wdata;
                end
            end
        endcase
        // pins are registered from the next state so they change on the same edge as the state
        ce_n_d  = !(state_d == RD || state_d == WR);
        oe_n_d  = state_d != RD;
        we_n_d  = state_d != WR;
        ub_n_d  = (state_d == RD) ? 1'b0 : (state_d == WR) ? ~be_d[1] : 1'b1;
        lb_n_d  = (state_d == RD) ? 1'b0 : (state_d == WR) ? ~be_d[0] : 1'b1;
        // keep driving for one cycle after we_n rises so the SRAM sees data hold
        dq_oe_d = (state_d == WR) || (state_d == DONE && state_q == WR);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            src_q       <= SRC_VGA;
            be_q        <= 2'b00;
            addr_q      <= '0;
            dq_out_q    <= '0;
            vga_rdata_q <= '0;
            cpu_rdata_q <= '0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            src_q       <= src_d;
            be_q        <= be_d;
            addr_q      <= addr_d;
            dq_out_q    <= dq_out_d;
            vga_rdata_q <= vga_rdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            ub_n_q      <= ub_n_d;
            lb_n_q      <= lb_n_d;
            dq_oe_q     <= dq_oe_d;
        end
    end
    assign state       = state_q;
    assign src         = src_q;
    assign vga_rdata   = vga_rdata_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_ub_n   = ub_n_q;
    assign sram_lb_n   = lb_n_q;
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one async 16-bit SRAM between a VGA read port and a CPU Avalon-MM port
//  vga_*:  req/addr in, gnt pulse on acceptance, rvalid pulse with rdata
//  cpu_*:  Avalon-MM slave (address/read/write/writedata/byteenable in, readdata/waitrequest out)
//  sram_*: registered SRAM pins with split tristate data (dq_out/dq_oe/dq_in)
module sram_port_arbiter import sram_arb_pkg::*; #(
    parameter int RD_CYCLES    = 2,
    parameter int WR_CYCLES    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic          vga_gnt,
    output logic          vga_rvalid,
    output logic [DW-1:0] vga_rdata,
    input  logic [AW-1:0] cpu_address,
    input  logic          cpu_read,
    input  logic          cpu_write,
    input  logic [DW-1:0] cpu_writedata,
    input  logic [1:0]    cpu_byteenable,
    output logic [DW-1:0] cpu_readdata,
    output logic          cpu_waitrequest,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_dq_out,
    output logic          sram_dq_oe,
    input  logic [DW-1:0] sram_dq_in,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic          sram_ub_n,
    output logic          sram_lb_n
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    state_t state;
    logic src, arb_ok, cpu_req, cpu_done, cpu_elig, cpu_win, vga_win;
    logic [SW-1:0] starve_q, starve_d;
    always_comb begin
        arb_ok   = state == IDLE || state == DONE;
        cpu_req  = cpu_read || cpu_write;
        cpu_done = state == DONE && src == SRC_CPU;
        // the CPU's own completing request must not re-grant while the master still holds it
        cpu_elig = arb_ok && cpu_req && !cpu_done;
        cpu_win  = cpu_elig && (starve_q == SW'(STARVE_LIMIT) || !vga_req);
        vga_win  = arb_ok && vga_req && !cpu_win && !reset;
        starve_d = cpu_win ? '0 : (vga_win && cpu_elig && starve_q != SW'(STARVE_LIMIT)) ? starve_q + 1'b1 : starve_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) starve_q <= '0;
        else starve_q <= starve_d;
    end
    assign vga_gnt         = vga_win;
    assign vga_rvalid      = state == DONE && src == SRC_VGA;
    assign cpu_waitrequest = cpu_req && !cpu_done;
    sram_access_seq #(.RD_CYCLES(RD_CYCLES), .WR_CYCLES(WR_CYCLES)) u_seq (
        .clk        (clk),
        .reset      (reset),
        .start      (vga_win || cpu_win),
        .start_src  (cpu_win ? SRC_CPU : SRC_VGA),
        .start_write(cpu_win && !cpu_read),
        .start_addr (cpu_win ? cpu_address : vga_addr),
        .start_wdata(cpu_writedata),
        .start_be   (cpu_win ? cpu_byteenable : 2'b11),
        .state      (state),
        .src        (src),
        .vga_rdata  (vga_rdata),
        .cpu_rdata  (cpu_readdata),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_ub_n  (sram_ub_n),
        .sram_lb_n  (sram_lb_n)
    );
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed self-checking bench for sram_port_arbiter with a byte-lane SRAM model
module tb_sram_port_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic vga_req = 1'b0, cpu_read = 1'b0, cpu_write = 1'b0;
    logic [19:0] vga_addr = '0, cpu_address = '0;
    logic [15:0] cpu_writedata = '0;
    logic [1:0] cpu_byteenable = '0;
    logic vga_gnt, vga_rvalid, cpu_waitrequest, sram_dq_oe;
    logic sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
    logic [15:0] vga_rdata, cpu_readdata, sram_dq_out, sram_dq_in;
    logic [19:0] sram_addr;
    logic [15:0] mem [0:1023];
    logic pre_we = 1'b0;
    logic [9:0] pre_a = '0;
    logic [15:0] pre_d = '0;
    int checks = 0, failures = 0;
    always #5 clk = ~clk;
    sram_port_arbiter dut (
        .clk(clk), .reset(reset),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_writedata(cpu_writedata),
        .cpu_byteenable(cpu_byteenable), .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );
    always @(posedge clk) begin
        if (pre_we) mem[pre_a] = pre_d;
        else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            if (!sram_ub_n) mem[sram_addr[9:0]][15:8] = sram_dq_out[15:8];
            if (!sram_lb_n) mem[sram_addr[9:0]][7:0] = sram_dq_out[7:0];
        end
    end
    assign sram_dq_in = mem[sram_addr[9:0]];
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic pre(input logic [9:0] a, input logic [15:0] d);
        pre_a = a;
        pre_d = d;
        pre_we = 1'b1;
        step();
        pre_we = 1'b0;
    endtask
    initial begin
        int n, ng, nr;
        logic gflag;
        step();
        pre(10'h010, 16'hBEEF);
        pre(10'h345, 16'h1122);
        pre(10'h020, 16'h1234);
        pre(10'h030, 16'h5678);
        pre(10'h077, 16'h9999);
        pre(10'h055, 16'h0000);
        pre(10'h066, 16'h0000);
        for (int i = 0; i < 10; i++) pre(10'h100 + 10'(i), 16'hC000 + 16'(i));
        // reset state, with a CPU request and a VGA request pending
        cpu_read = 1'b1;
        vga_req = 1'b1;
        #1;
        chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);
        chk("rst_dq_oe", sram_dq_oe, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_gnt_rvalid", {vga_gnt, vga_rvalid}, 0);
        chk("rst_rdata", {vga_rdata, cpu_readdata}, 0);
        chk("rst_waitreq", cpu_waitrequest, 1);
        cpu_read = 1'b0;
        vga_req = 1'b0;
        #1;
        chk("rst_waitreq_idle", cpu_waitrequest, 0);
        reset = 1'b0;
        step();
        // 1: single VGA read
        vga_req = 1'b1;
        vga_addr = 20'h00010;
        #1;
        chk("t1_gnt_c0", vga_gnt, 1);
        step();
        vga_req = 1'b0;
        #1;
        chk("t1_c1_pins", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, sram_ub_n, sram_lb_n}, 6'b001000);
        chk("t1_c1_addr", sram_addr, 20'h00010);
        chk("t1_c1_gnt", vga_gnt, 0);
        step();
        chk("t1_c2_oe", sram_oe_n, 0);
        chk("t1_c2_rvalid", vga_rvalid, 0);
        step();
        chk("t1_c3_rvalid", vga_rvalid, 1);
        chk("t1_c3_rdata", vga_rdata, 16'hBEEF);
        chk("t1_c3_oe", sram_oe_n, 1);
        step();
        chk("t1_c4_rvalid", vga_rvalid, 0);
        // 2: CPU upper-byte write
        cpu_write = 1'b1;
        cpu_address = 20'h12345;
        cpu_writedata = 16'hA5C3;
        cpu_byteenable = 2'b10;
        #1;
        chk("t2_c0_wait", cpu_waitrequest, 1);
        step();
        chk("t2_c1_pins", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, sram_ub_n, sram_lb_n}, 6'b010101);
        chk("t2_c1_dq", sram_dq_out, 16'hA5C3);
        chk("t2_c1_addr", sram_addr, 20'h12345);
        step();
        chk("t2_c2_we", sram_we_n, 0);
        step();
        chk("t2_c3_we", {sram_we_n, sram_ce_n, sram_dq_oe}, 3'b111);
        chk("t2_c3_wait", cpu_waitrequest, 0);
        cpu_write = 1'b0;
        step();
        chk("t2_c4_dq_oe", sram_dq_oe, 0);
        chk("t2_mem", mem[10'h345], 16'hA522);
        // 3: simultaneous VGA and CPU read, VGA first
        vga_req = 1'b1;
        vga_addr = 20'h00030;
        cpu_read = 1'b1;
        cpu_address = 20'h00020;
        #1;
        chk("t3_vga_first", vga_gnt, 1);
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 1) vga_req = 1'b0;
            #1;
            chk("t3_wait_high", cpu_waitrequest, 1);
            if (i == 3) chk("t3_vga_data", {vga_rvalid, vga_rdata}, {1'b1, 16'h5678});
        end
        step();
        chk("t3_c6_wait", cpu_waitrequest, 0);
        chk("t3_c6_data", cpu_readdata, 16'h1234);
        cpu_read = 1'b0;
        step();
        // 4: starvation guard
        vga_req = 1'b1;
        cpu_read = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (vga_gnt) n++;
            step();
        end
        chk("t4_vga_grants", n, 4);
        #1;
        chk("t4_c12_cpu_wins", {vga_gnt, cpu_waitrequest}, 2'b01);
        step();
        chk("t4_starve_clear", dut.starve_q, 0);
        step();
        step();
        chk("t4_c15_wait", cpu_waitrequest, 0);
        chk("t4_c15_data", cpu_readdata, 16'h1234);
        chk("t4_c15_vga_gnt", vga_gnt, 1);
        cpu_read = 1'b0;
        step();
        vga_req = 1'b0;
        step();
        step();
        chk("t4_vga_done", {vga_rvalid, vga_rdata}, {1'b1, 16'h5678});
        step();
        // 5: ten back-to-back VGA reads
        vga_addr = 20'h00100;
        vga_req = 1'b1;
        ng = 0;
        nr = 0;
        gflag = 1'b0;
        for (int i = 0; i < 34; i++) begin
            if (gflag) begin
                gflag = 1'b0;
                if (ng == 10) vga_req = 1'b0;
                else vga_addr = vga_addr + 20'd1;
            end
            #1;
            if (vga_gnt) begin
                ng++;
                gflag = 1'b1;
            end
            if (vga_rvalid) begin
                chk("t5_rdata", vga_rdata, 32'hC000 + nr);
                chk("t5_rvalid_cycle", i, 3 * (nr + 1));
                nr++;
            end
            step();
        end
        chk("t5_count", nr, 10);
        // write with no byte lanes enabled
        cpu_write = 1'b1;
        cpu_address = 20'h00077;
        cpu_writedata = 16'h0000;
        cpu_byteenable = 2'b00;
        step();
        chk("be0_lanes", {sram_we_n, sram_ub_n, sram_lb_n}, 3'b011);
        step();
        step();
        chk("be0_done", cpu_waitrequest, 0);
        cpu_write = 1'b0;
        step();
        chk("be0_mem", mem[10'h077], 16'h9999);
        // 6: reset during WR c1
        cpu_write = 1'b1;
        cpu_address = 20'h00055;
        cpu_writedata = 16'h7777;
        cpu_byteenable = 2'b11;
        step();
        chk("t6_c1_we", sram_we_n, 0);
        reset = 1'b1;
        #1;
        chk("t6_async_pins", {sram_we_n, sram_ce_n, sram_dq_oe}, 3'b110);
        cpu_write = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        chk("t6_lost_write", mem[10'h055], 16'h0000);
        cpu_write = 1'b1;
        cpu_address = 20'h00066;
        cpu_writedata = 16'h3C3C;
        cpu_byteenable = 2'b01;
        step();
        step();
        step();
        chk("t6_fresh_done", cpu_waitrequest, 0);
        cpu_write = 1'b0;
        step();
        chk("t6_fresh_mem", mem[10'h066], 16'h003C);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
